// File: rtl/cpu5_pkg.sv
// Shared definitions for the 5-bit CPU: word widths, opcodes, FSM states.
// Imported by the sequencer, its PC counter, the bus interface and the bench.
package cpu5_pkg;

    localparam int DW = 5;
    localparam int AW = 3;

    localparam logic [1:0] OP_LD  = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_JMP = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

endpackage

// File: rtl/cpu5_ld_sequencer_if.sv
// Memory + accumulator bus of the sequencer.
// master: drives mem_addr, acc_din, acc_sel; reads mem_rdata.
// slave:  memory/accumulator side, drives mem_rdata.
interface cpu5_ld_sequencer_if;
    import cpu5_pkg::*;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] acc_din;
    logic          acc_sel;

    modport master (
        output mem_addr,
        output acc_din,
        output acc_sel,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  acc_din,
        input  acc_sel,
        output mem_rdata
    );

endinterface

// File: rtl/cpu5_pc_counter.sv
// AW-bit program counter: sync reset, parallel load, increment (wraps).
// Ports: clk, reset, inc, load, d (load value), q (current PC).
module cpu5_pc_counter
    import cpu5_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] d,
    output logic [AW-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cpu5_ld_sequencer.sv
// Fetch/decode/execute sequencer for the 5-bit CPU (LD, LDI, JMP, HLT).
// Ports: clk, reset, run, bus (mem_addr/mem_rdata/acc_din/acc_sel),
//        instr_done, halted, pc.
module cpu5_ld_sequencer
    import cpu5_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    cpu5_ld_sequencer_if.master  bus,
    output logic                 instr_done,
    output logic                 halted,
    output logic [AW-1:0]        pc
);

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] ir;
    logic [1:0]    opcode;
    logic [AW-1:0] operand;
    logic          pc_inc;
    logic          pc_load;

    assign opcode  = ir[DW-1:AW];
    assign operand = ir[AW-1:0];
    assign pc_inc  = (state == FETCH);
    assign pc_load = (state == EXEC) && (opcode == OP_JMP);

    cpu5_pc_counter u_pc (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_inc),
        .load  (pc_load),
        .d     (operand),
        .q     (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (state == FETCH) begin
            ir <= bus.mem_rdata;
        end
    end

    always_comb begin
        state_nxt    = IDLE;
        bus.mem_addr = '0;
        bus.acc_din  = '0;
        bus.acc_sel  = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = run ? FETCH : IDLE;
            end
            FETCH: begin
                bus.mem_addr = pc;
                state_nxt    = DECODE;
            end
            DECODE: begin
                if (opcode == OP_HLT) begin
                    instr_done = 1'b1;
                    state_nxt  = HALT;
                end else begin
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                bus.mem_addr = operand;
                instr_done   = 1'b1;
                if (opcode == OP_LD) begin
                    bus.acc_din = bus.mem_rdata;
                    bus.acc_sel = 1'b1;
                end else if (opcode == OP_LDI) begin
                    bus.acc_din = {{(DW-AW){1'b0}}, operand};
                    bus.acc_sel = 1'b1;
                end
                state_nxt = run ? FETCH : IDLE;
            end
            HALT: begin
                halted    = 1'b1;
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A reset landing in EXEC/DECODE aborts the instruction: no strobes.
        if (reset) begin
            bus.acc_sel = 1'b0;
            bus.acc_din = '0;
            instr_done  = 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu5_ld_sequencer.sv
// Directed bench for cpu5_ld_sequencer with a small behavioural memory.
// Expected values are hand-computed per cycle from the program images.
module tb_cpu5_ld_sequencer;
    import cpu5_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          instr_done;
    logic          halted;
    logic [AW-1:0] pc;
    logic [DW-1:0] mem [8];

    int checks = 0;
    int errors = 0;
    int dn;
    int sl;

    cpu5_ld_sequencer_if bus ();

    assign bus.mem_rdata = mem[bus.mem_addr];

    cpu5_ld_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .bus        (bus),
        .instr_done (instr_done),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = 5'h05;
        mem[1] = 5'h0B;
        mem[2] = 5'h14;
        mem[4] = 5'h18;
        mem[5] = 5'h16;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        // Program run from reset, then HALT robustness.
        load_prog();
        run = 1'b1;
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_sel", 32'(bus.acc_sel), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_done", 32'(instr_done), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        dn = 0;
        sl = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            dn += int'(instr_done);
            sl += int'(bus.acc_sel);
            if (c == 1) check("f0_addr", 32'(bus.mem_addr), 32'd0);
            if (c == 3) begin
                check("ld_sel", 32'(bus.acc_sel), 32'd1);
                check("ld_din", 32'(bus.acc_din), 32'h16);
                check("ld_addr", 32'(bus.mem_addr), 32'd5);
            end
            if (c == 6) begin
                check("ldi_sel", 32'(bus.acc_sel), 32'd1);
                check("ldi_din", 32'(bus.acc_din), 32'h03);
            end
            if (c == 10) check("jmp_pc", 32'(pc), 32'd4);
            if (c == 11) check("hlt_dec", 32'(halted), 32'd0);
            if (c >= 12) check("halted", 32'(halted), 32'd1);
        end
        check("n_done", 32'(dn), 32'd4);
        check("n_sel", 32'(sl), 32'd2);
        check("halt_pc", 32'(pc), 32'd5);
        for (int i = 0; i < 10; i++) begin
            run = ~run;
            tick();
            check("h_halt", 32'(halted), 32'd1);
            check("h_sel", 32'(bus.acc_sel), 32'd0);
            check("h_pc", 32'(pc), 32'd5);
        end

        // Drop run during DECODE of LD 5, then resume.
        load_prog();
        run = 1'b1;
        do_reset();
        tick();
        tick();
        run = 1'b0;
        tick();
        check("stop_sel", 32'(bus.acc_sel), 32'd1);
        check("stop_din", 32'(bus.acc_din), 32'h16);
        tick();
        check("stop_st", 32'(dut.state), 32'(IDLE));
        check("stop_pc", 32'(pc), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_done", 32'(instr_done), 32'd0);
            check("idle_sel", 32'(bus.acc_sel), 32'd0);
            check("idle_pc", 32'(pc), 32'd1);
            check("idle_addr", 32'(bus.mem_addr), 32'd0);
        end
        run = 1'b1;
        tick();
        check("res_addr", 32'(bus.mem_addr), 32'd1);
        tick();
        tick();
        check("res_sel", 32'(bus.acc_sel), 32'd1);
        check("res_din", 32'(bus.acc_din), 32'h03);

        // PC wrap: JMP 7 at M0, LDI 2 at M7, then M0 rewritten to HLT.
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = 5'h17;
        mem[7] = 5'h0A;
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        check("w_jmp_sel", 32'(bus.acc_sel), 32'd0);
        mem[0] = 5'h18;
        tick();
        check("w_addr7", 32'(bus.mem_addr), 32'd7);
        tick();
        check("w_wrap", 32'(pc), 32'd0);
        tick();
        check("w_sel", 32'(bus.acc_sel), 32'd1);
        check("w_din", 32'(bus.acc_din), 32'h02);
        tick();
        check("w_addr0", 32'(bus.mem_addr), 32'd0);
        tick();
        check("w_done", 32'(instr_done), 32'd1);
        tick();
        check("w_halt", 32'(halted), 32'd1);
        check("w_pc", 32'(pc), 32'd1);

        // Reset in the EXEC cycle of LD 5.
        load_prog();
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("ra_sel", 32'(bus.acc_sel), 32'd0);
        check("ra_done", 32'(instr_done), 32'd0);
        tick();
        reset = 1'b0;
        check("ra_state", 32'(dut.state), 32'(IDLE));
        check("ra_pc", 32'(pc), 32'd0);
        check("ra_ir", 32'(dut.ir), 32'd0);
        check("ra_addr", 32'(bus.mem_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
